// File: rtl/nixie_pkg.sv
// Shared definitions for the nixie/seven-segment scan controller.
package nixie_pkg;

    // Width of one packed digit value
    localparam int VAL_W = 3;

    // Segment pattern with every segment off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Scan FSM: all digits dark, or one digit lit
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Larger of two integers, used to size the shared duration counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nixie_seg_decode.sv
// Combinational 3-bit value to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module nixie_seg_decode
    import nixie_pkg::*;
(
    input  logic [VAL_W-1:0] val,
    output logic [6:0]       seg
);

    // Fixed glyph table for values 0..7
    always_comb begin
        seg = SEG_BLANK;
        case (val)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            3'd7:    seg = 7'b1111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/nixie_scan_ctrl.sv
// Time-multiplexed scan controller for the front-panel seven-segment display.
// One decoder is shared across DIGITS positions; a BLANK gap separates every
// lit slot. New values are staged on load and copied to the displayed
// (shadow) set only at the frame boundary, so a frame never shows a mix.
// Optional blinking is built when the macro NIXIE_BLINK_EN is defined.
module nixie_scan_ctrl
    import nixie_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 8,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [VAL_W*DIGITS-1:0] digit_val,
    input  logic [DIGITS-1:0]       digit_en,
    input  logic [DIGITS-1:0]       blink_mask,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       an,
    output logic                    frame_done
);

    localparam int CNT_MAX = max_int(SCAN_DIV, BLANK_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SLOT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIGITS - 1);

    scan_state_t               state_q, state_d;
    logic [SLOT_W-1:0]         slot_q, slot_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [VAL_W*DIGITS-1:0]   stage_val_q, stage_val_d;
    logic [DIGITS-1:0]         stage_en_q, stage_en_d;
    logic [VAL_W*DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]         shadow_en_q, shadow_en_d;
    logic [6:0]                seg_q, seg_d;
    logic [DIGITS-1:0]         an_q, an_d;
    logic                      frame_done_q, frame_done_d;
    logic                      frame_edge;
    logic                      blink_hide;

    // Per-digit view of the displayed values so the current slot can be selected
    logic [VAL_W-1:0] shadow_digit [DIGITS];
    logic [VAL_W-1:0] cur_val;
    logic [6:0]       cur_seg;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
        assign shadow_digit[gi] = shadow_val_q[gi*VAL_W +: VAL_W];
    end

    assign cur_val = shadow_digit[slot_q];

    nixie_seg_decode u_decode (
        .val (cur_val),
        .seg (cur_seg)
    );

`ifdef NIXIE_BLINK_EN
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    logic [DIGITS-1:0] stage_mask_q, stage_mask_d;
    logic [DIGITS-1:0] shadow_mask_q, shadow_mask_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              phase_q, phase_d;

    // Blink mask staging/shadowing and the frame counter that flips the phase
    always_comb begin
        stage_mask_d  = load ? blink_mask : stage_mask_q;
        shadow_mask_d = shadow_mask_q;
        fcnt_d        = fcnt_q;
        phase_d       = phase_q;
        if (frame_edge) begin
            shadow_mask_d = load ? blink_mask : stage_mask_q;
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign blink_hide = phase_q & shadow_mask_q[slot_q];
`else
    // Without blinking the mask input has no effect
    logic unused_blink;
    assign unused_blink = (^blink_mask) ^ BLINK_FRAMES[0];
    assign blink_hide   = 1'b0;
`endif

    // Next-state, slot/counter sequencing, double-buffer update and output patterns
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        frame_edge   = 1'b0;
        stage_val_d  = load ? digit_val : stage_val_q;
        stage_en_d   = load ? digit_en  : stage_en_q;
        shadow_val_d = shadow_val_q;
        shadow_en_d  = shadow_en_q;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (slot_q == SLOT_LAST) begin
                        slot_d     = '0;
                        frame_edge = 1'b1;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase

        // A load on the boundary cycle bypasses staging so it shows immediately
        if (frame_edge) begin
            shadow_val_d = load ? digit_val : stage_val_q;
            shadow_en_d  = load ? digit_en  : stage_en_q;
        end

        frame_done_d = frame_edge;

        // Outputs follow the state being entered; shadow/slot are stable while SHOW
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (state_d == SHOW && shadow_en_q[slot_q] && !blink_hide) begin
            seg_d         = cur_seg;
            an_d[slot_q]  = 1'b0;
        end
    end

    // All state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BLANK;
            slot_q       <= '0;
            cnt_q        <= '0;
            stage_val_q  <= '0;
            stage_en_q   <= '0;
            shadow_val_q <= '0;
            shadow_en_q  <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_done_q <= 1'b0;
`ifdef NIXIE_BLINK_EN
            stage_mask_q  <= '0;
            shadow_mask_q <= '0;
            fcnt_q        <= '0;
            phase_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            stage_val_q  <= stage_val_d;
            stage_en_q   <= stage_en_d;
            shadow_val_q <= shadow_val_d;
            shadow_en_q  <= shadow_en_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
`ifdef NIXIE_BLINK_EN
            stage_mask_q  <= stage_mask_d;
            shadow_mask_q <= shadow_mask_d;
            fcnt_q        <= fcnt_d;
            phase_q       <= phase_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// Self-checking bench for nixie_scan_ctrl (DIGITS=4, SCAN_DIV=4, BLANK_CYC=2).
// The reference model works purely from elapsed cycles since reset:
// frame = t/24, slot = (t%24)/6, lit when (t%24)%6 >= 2.
module tb_nixie_scan_ctrl;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYC    = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int SLOT_LEN     = SCAN_DIV + BLANK_CYC;
    localparam int FRAME_LEN    = DIGITS * SLOT_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [11:0] digit_val = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    nixie_scan_ctrl #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digit_val  (digit_val),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since reset plus staged/displayed data
    int          t = 0;
    logic [11:0] m_stage_val = '0, m_shad_val = '0;
    logic [3:0]  m_stage_en = '0, m_shad_en = '0;
    logic [3:0]  m_stage_mask = '0, m_shad_mask = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] tbl [8];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
        return tbl[v];
    endfunction

    // One clock: advance model with the inputs presented, then compare outputs
    task automatic step();
        int          r, slot, ph, frame;
        bit          hide, vis;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        @(posedge clk);
        if (rst) begin
            t = 0;
            m_stage_val = '0; m_stage_en = '0; m_stage_mask = '0;
            m_shad_val  = '0; m_shad_en  = '0; m_shad_mask  = '0;
        end else begin
            t++;
            if (load) begin
                m_stage_val  = digit_val;
                m_stage_en   = digit_en;
                m_stage_mask = blink_mask;
                $display("load t=%0d val=%h en=%b mask=%b", t, digit_val, digit_en, blink_mask);
            end
            if (t % FRAME_LEN == 0) begin
                m_shad_val  = m_stage_val;
                m_shad_en   = m_stage_en;
                m_shad_mask = m_stage_mask;
            end
        end
        #1;
        r     = t % FRAME_LEN;
        slot  = r / SLOT_LEN;
        ph    = r % SLOT_LEN;
        frame = t / FRAME_LEN;
`ifdef NIXIE_BLINK_EN
        hide = ((frame / BLINK_FRAMES) % 2 == 1) && m_shad_mask[slot];
`else
        hide = 1'b0;
`endif
        vis     = (ph >= BLANK_CYC) && m_shad_en[slot] && !hide;
        exp_an  = 4'hF;
        exp_seg = 7'b1111111;
        if (vis) begin
            exp_an[slot] = 1'b0;
            exp_seg      = glyph(int'(m_shad_val[slot*3 +: 3]));
        end
        check_val("an", 32'(an), 32'(exp_an));
        check_val("seg", 32'(seg), 32'(exp_seg));
        check_val("frame_done", 32'(frame_done), 32'((t > 0 && r == 0) ? 1 : 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next edge will land at frame position pos (bounded)
    task automatic run_until_pos(input int pos);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if ((t + 1) % FRAME_LEN == pos) break;
            step();
        end
    endtask

    task automatic do_load(input logic [11:0] v, input logic [3:0] en, input logic [3:0] mask);
        digit_val  = v;
        digit_en   = en;
        blink_mask = mask;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    initial begin
        // Reset held for three cycles
        rst = 1'b1;
        run(3);
        rst = 1'b0;

        // {3,2,1,0} before the first boundary, then two full frames
        do_load({3'd3, 3'd2, 3'd1, 3'd0}, 4'hF, 4'h0);
        run(2 * FRAME_LEN);

        // Mid-frame load during slot 1 SHOW
        run_until_pos(9);
        do_load({3'd7, 3'd7, 3'd7, 3'd7}, 4'hF, 4'h0);
        run(FRAME_LEN + 4);

        // Load exactly on the boundary cycle
        run_until_pos(0);
        do_load({3'd4, 3'd5, 3'd6, 3'd1}, 4'hF, 4'h0);
        run(FRAME_LEN);

        // Digit 2 disabled
        do_load({3'd1, 3'd2, 3'd3, 3'd4}, 4'b1011, 4'h0);
        run(2 * FRAME_LEN);

        // Reset during slot 2 SHOW, then show zeros
        run_until_pos(15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_load(12'h000, 4'hF, 4'h0);
        run(2 * FRAME_LEN);

        // Blink on digit 0
        do_load({3'd6, 3'd5, 3'd4, 3'd3}, 4'hF, 4'b0001);
        run(6 * FRAME_LEN);

        // Randomized loads, boundary loads and occasional resets
        for (int i = 0; i < 1200; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            load = 1'b0;
            if (!rst) begin
                if ((t + 1) % FRAME_LEN == 0) load = ($urandom_range(0, 1) == 1);
                else                          load = ($urandom_range(0, 7) == 0);
            end
            digit_val  = 12'($urandom);
            digit_en   = 4'($urandom);
            blink_mask = 4'($urandom);
            step();
        end
        rst  = 1'b0;
        load = 1'b0;
        run(FRAME_LEN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
